// File: rtl/axistream_snooper_keep.sv
// axistream_snooper_keep: passive AXI Stream snooper. It copies each observed
// packet into packet memory and reports the packet's byte length (from TKEEP)
// and whether it was truncated.
//
// Ports:
//   axi_aclk, axi_aresetn      clock, asynchronous active-low reset
//   TDATA/TKEEP/TVALID/TREADY/TLAST   snooped stream (inputs only)
//   mem_ready                  packet memory has a free buffer
//   wr_addr/wr_data/wr_en      packet-memory write port (registered)
//   done                       one-cycle pulse when a buffer is complete
//   byte_len, trunc            packet byte count and overflow flag, valid with done
//   pkt_count, drop_count, trunc_count   32-bit saturating statistics
//                                        (only when SNOOP_STATS_EN is defined)
//
// Optional feature macro: SNOOP_STATS_EN
module axistream_snooper_keep #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + $clog2(KEEP_WIDTH) + 1
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [DATA_WIDTH-1:0] TDATA,
    input  logic [KEEP_WIDTH-1:0] TKEEP,
    input  logic                  TVALID,
    input  logic                  TREADY,
    input  logic                  TLAST,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  byte_len,
    output logic                  trunc
`ifdef SNOOP_STATS_EN
    ,
    output logic [31:0]           pkt_count,
    output logic [31:0]           drop_count,
    output logic [31:0]           trunc_count
`endif
);

    localparam int unsigned FULL_LEN = KEEP_WIDTH * (1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DISCARD = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt, w_eff;
    logic                  w_beat;
    logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_nxt;
    logic [LEN_WIDTH-1:0]  r_len_pend, w_len_pend_nxt;
    logic                  r_trunc_pend, w_trunc_pend_nxt;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_wr_addr;

    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_wr_en;
    logic                  r_done;
    logic [LEN_WIDTH-1:0]  r_byte_len;
    logic                  r_trunc;

    // Number of valid bytes in a TKEEP vector.
    function automatic logic [LEN_WIDTH-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [LEN_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < int'(KEEP_WIDTH); i++) begin
            c = c + LEN_WIDTH'(k[i]);
        end
        return c;
    endfunction

    assign w_beat = TVALID && TREADY;

    // The DONE cycle lasts one cycle; a beat arriving in it is handled by the
    // state that follows DONE, so decode from that "effective" state.
    always_comb begin
        w_eff = r_state;
        if (r_state == DONE) begin
            w_eff = r_trunc_pend ? DISCARD : IDLE;
        end
    end

    // Next-state and write-port decode.
    always_comb begin
        w_state_nxt      = w_eff;
        w_ptr_nxt        = r_ptr;
        w_len_pend_nxt   = r_len_pend;
        w_trunc_pend_nxt = r_trunc_pend;
        w_wr             = 1'b0;
        w_wr_addr        = '0;
        case (w_eff)
            IDLE: begin
                if (w_beat && mem_ready) begin
                    w_wr             = 1'b1;
                    w_wr_addr        = '0;
                    w_ptr_nxt        = ADDR_WIDTH'(1);
                    w_trunc_pend_nxt = 1'b0;
                    if (TLAST) begin
                        w_state_nxt    = DONE;
                        w_len_pend_nxt = popcount(TKEEP);
                    end else begin
                        w_state_nxt = CAPTURE;
                    end
                end else if (w_beat && !TLAST) begin
                    w_state_nxt = DISCARD;
                end
            end
            CAPTURE: begin
                if (w_beat) begin
                    w_wr      = 1'b1;
                    w_wr_addr = r_ptr;
                    if (TLAST) begin
                        w_state_nxt    = DONE;
                        w_len_pend_nxt = LEN_WIDTH'(r_ptr) * LEN_WIDTH'(KEEP_WIDTH)
                                         + popcount(TKEEP);
                    end else if (r_ptr == ADDR_MAX) begin
                        // Buffer full with packet still open: report and drop the rest.
                        w_state_nxt      = DONE;
                        w_len_pend_nxt   = LEN_WIDTH'(FULL_LEN);
                        w_trunc_pend_nxt = 1'b1;
                    end else begin
                        w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
                    end
                end
            end
            DISCARD: begin
                if (w_beat && TLAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_len_pend   <= '0;
            r_trunc_pend <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_done       <= 1'b0;
            r_byte_len   <= '0;
            r_trunc      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_len_pend   <= w_len_pend_nxt;
            r_trunc_pend <= w_trunc_pend_nxt;
            r_wr_en      <= w_wr;
            if (w_wr) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= TDATA;
            end
            r_done     <= (r_state == DONE);
            r_byte_len <= (r_state == DONE) ? r_len_pend : '0;
            r_trunc    <= (r_state == DONE) && r_trunc_pend;
        end
    end

    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign wr_en    = r_wr_en;
    assign done     = r_done;
    assign byte_len = r_byte_len;
    assign trunc    = r_trunc;

`ifdef SNOOP_STATS_EN
    logic        r_drop;
    logic        w_drop_evt;
    logic [31:0] r_pkt_count, r_drop_count, r_trunc_count;

    // A packet is dropped when its final beat is seen without ever being written.
    assign w_drop_evt = w_beat && TLAST &&
                        (((w_eff == IDLE) && !mem_ready) || ((w_eff == DISCARD) && r_drop));

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_drop        <= 1'b0;
            r_pkt_count   <= '0;
            r_drop_count  <= '0;
            r_trunc_count <= '0;
        end else begin
            if (w_beat && (w_eff == IDLE)) begin
                r_drop <= !mem_ready;
            end
            if ((r_state == DONE) && (r_pkt_count != '1)) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if ((r_state == DONE) && r_trunc_pend && (r_trunc_count != '1)) begin
                r_trunc_count <= r_trunc_count + 32'd1;
            end
            if (w_drop_evt && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

    assign pkt_count   = r_pkt_count;
    assign drop_count  = r_drop_count;
    assign trunc_count = r_trunc_count;
`endif

endmodule

// File: tb/tb_axistream_snooper_keep.sv
module tb_axistream_snooper_keep;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 6;
    localparam int unsigned KW = 8;
    localparam int unsigned LW = 10;

    logic          axi_aclk;
    logic          axi_aresetn;
    logic [DW-1:0] TDATA;
    logic [KW-1:0] TKEEP;
    logic          TVALID;
    logic          TREADY;
    logic          TLAST;
    logic          mem_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          done;
    logic [LW-1:0] byte_len;
    logic          trunc;

    int n_checks = 0;
    int n_pass   = 0;

    axistream_snooper_keep #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .axi_aclk   (axi_aclk),
        .axi_aresetn(axi_aresetn),
        .TDATA      (TDATA),
        .TKEEP      (TKEEP),
        .TVALID     (TVALID),
        .TREADY     (TREADY),
        .TLAST      (TLAST),
        .mem_ready  (mem_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .done       (done),
        .byte_len   (byte_len),
        .trunc      (trunc)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    // Cycle counter and logs of everything the DUT emits.
    int cyc = 0;
    always @(posedge axi_aclk) cyc <= cyc + 1;

    int            wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            wc_q[$];
    int            dc_q[$];
    int            dl_q[$];
    int            dt_q[$];

    always @(negedge axi_aclk) begin
        if (wr_en) begin
            wa_q.push_back(int'(wr_addr));
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
        if (done) begin
            dc_q.push_back(cyc);
            dl_q.push_back(int'(byte_len));
            dt_q.push_back(int'(trunc));
        end
    end

    function automatic int get_wa(input int i);
        return (i < wa_q.size()) ? wa_q[i] : -1;
    endfunction
    function automatic logic [DW-1:0] get_wd(input int i);
        return (i < wd_q.size()) ? wd_q[i] : '1;
    endfunction
    function automatic int get_wc(input int i);
        return (i < wc_q.size()) ? wc_q[i] : -100;
    endfunction
    function automatic int get_dc(input int i);
        return (i < dc_q.size()) ? dc_q[i] : -200;
    endfunction
    function automatic int get_dl(input int i);
        return (i < dl_q.size()) ? dl_q[i] : -1;
    endfunction
    function automatic int get_dt(input int i);
        return (i < dt_q.size()) ? dt_q[i] : -1;
    endfunction

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        dc_q.delete(); dl_q.delete(); dt_q.delete();
    endtask

    task automatic drive(input logic v, input logic r, input logic l,
                         input logic [KW-1:0] k, input logic [DW-1:0] d);
        @(negedge axi_aclk);
        TVALID = v; TREADY = r; TLAST = l; TKEEP = k; TDATA = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        axi_aresetn = 1'b0;
        TVALID = 1'b0; TREADY = 1'b0; TLAST = 1'b0; TKEEP = '0; TDATA = '0;
        mem_ready = 1'b1;
        repeat (3) @(negedge axi_aclk);
        n_checks++; if (wr_addr !== '0) $display("FAIL reset_wr_addr got=%0h exp=0", wr_addr); else n_pass++;
        n_checks++; if (wr_data !== '0) $display("FAIL reset_wr_data got=%0h exp=0", wr_data); else n_pass++;
        n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got=%b exp=0", wr_en); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_checks++; if (byte_len !== '0) $display("FAIL reset_byte_len got=%0d exp=0", byte_len); else n_pass++;
        n_checks++; if (trunc !== 1'b0) $display("FAIL reset_trunc got=%b exp=0", trunc); else n_pass++;
        axi_aresetn = 1'b1;
        idle(2);
        clear_logs();
    endtask

    task automatic test_basic();
        drive(1, 1, 0, 8'hFF, 64'h1111);
        drive(1, 1, 0, 8'hFF, 64'h2222);
        drive(1, 1, 1, 8'h0F, 64'h3333);
        idle(5);
        n_checks++; if (wa_q.size() !== 3) $display("FAIL basic_nwrites got=%0d exp=3", wa_q.size()); else n_pass++;
        n_checks++; if (get_wa(0) !== 0 || get_wa(1) !== 1 || get_wa(2) !== 2)
            $display("FAIL basic_addrs got=%0d,%0d,%0d exp=0,1,2", get_wa(0), get_wa(1), get_wa(2)); else n_pass++;
        n_checks++; if (get_wd(2) !== 64'h3333) $display("FAIL basic_data got=%0h exp=3333", get_wd(2)); else n_pass++;
        n_checks++; if (get_wc(1) !== get_wc(0) + 1 || get_wc(2) !== get_wc(0) + 2)
            $display("FAIL basic_consecutive got=%0d,%0d,%0d", get_wc(0), get_wc(1), get_wc(2)); else n_pass++;
        n_checks++; if (dc_q.size() !== 1) $display("FAIL basic_ndone got=%0d exp=1", dc_q.size()); else n_pass++;
        n_checks++; if (get_dc(0) !== get_wc(2) + 1) $display("FAIL basic_done_cycle got=%0d exp=%0d", get_dc(0), get_wc(2) + 1); else n_pass++;
        n_checks++; if (get_dl(0) !== 20) $display("FAIL basic_byte_len got=%0d exp=20", get_dl(0)); else n_pass++;
        n_checks++; if (get_dt(0) !== 0) $display("FAIL basic_trunc got=%0d exp=0", get_dt(0)); else n_pass++;
        clear_logs();
    endtask

    task automatic test_drop();
        drive(1, 1, 0, 8'hFF, 64'hD0); mem_ready = 1'b0;
        drive(1, 1, 1, 8'hFF, 64'hD1); mem_ready = 1'b1;
        idle(2);
        drive(1, 1, 1, 8'hFF, 64'hE0);
        idle(4);
        n_checks++; if (wa_q.size() !== 1) $display("FAIL drop_nwrites got=%0d exp=1", wa_q.size()); else n_pass++;
        n_checks++; if (get_wa(0) !== 0) $display("FAIL drop_addr got=%0d exp=0", get_wa(0)); else n_pass++;
        n_checks++; if (get_wd(0) !== 64'hE0) $display("FAIL drop_data got=%0h exp=e0", get_wd(0)); else n_pass++;
        n_checks++; if (dc_q.size() !== 1) $display("FAIL drop_ndone got=%0d exp=1", dc_q.size()); else n_pass++;
        n_checks++; if (get_dl(0) !== 8) $display("FAIL drop_byte_len got=%0d exp=8", get_dl(0)); else n_pass++;
        clear_logs();
    endtask

    task automatic test_trunc();
        bit addrs_ok;
        for (int i = 0; i < 70; i++) drive(1, 1, (i == 69), 8'hFF, 64'(i));
        drive(1, 1, 1, 8'h03, 64'hCAFE);
        idle(5);
        addrs_ok = 1'b1;
        for (int i = 0; i < 64; i++) if (get_wa(i) !== i || get_wd(i) !== 64'(i)) addrs_ok = 1'b0;
        n_checks++; if (wa_q.size() !== 65) $display("FAIL trunc_nwrites got=%0d exp=65", wa_q.size()); else n_pass++;
        n_checks++; if (addrs_ok !== 1'b1) $display("FAIL trunc_addrs got=bad exp=0..63 in order"); else n_pass++;
        n_checks++; if (dc_q.size() !== 2) $display("FAIL trunc_ndone got=%0d exp=2", dc_q.size()); else n_pass++;
        n_checks++; if (get_dc(0) !== get_wc(63) + 1) $display("FAIL trunc_done_cycle got=%0d exp=%0d", get_dc(0), get_wc(63) + 1); else n_pass++;
        n_checks++; if (get_dl(0) !== 512) $display("FAIL trunc_byte_len got=%0d exp=512", get_dl(0)); else n_pass++;
        n_checks++; if (get_dt(0) !== 1) $display("FAIL trunc_flag got=%0d exp=1", get_dt(0)); else n_pass++;
        n_checks++; if (get_wa(64) !== 0 || get_wd(64) !== 64'hCAFE)
            $display("FAIL trunc_next_pkt got=addr%0d/%0h exp=addr0/cafe", get_wa(64), get_wd(64)); else n_pass++;
        n_checks++; if (get_dl(1) !== 2 || get_dt(1) !== 0)
            $display("FAIL trunc_next_len got=%0d/%0d exp=2/0", get_dl(1), get_dt(1)); else n_pass++;
        clear_logs();
    endtask

    task automatic test_stall();
        drive(1, 1, 0, 8'hFF, 64'h51);
        drive(1, 0, 1, 8'h01, 64'hBAD0);
        drive(0, 1, 1, 8'h01, 64'hBAD1);
        drive(1, 0, 0, 8'hFF, 64'hBAD2);
        drive(1, 1, 1, 8'h3F, 64'h52);
        idle(5);
        n_checks++; if (wa_q.size() !== 2) $display("FAIL stall_nwrites got=%0d exp=2", wa_q.size()); else n_pass++;
        n_checks++; if (get_wa(0) !== 0 || get_wa(1) !== 1) $display("FAIL stall_addrs got=%0d,%0d exp=0,1", get_wa(0), get_wa(1)); else n_pass++;
        n_checks++; if (get_wd(1) !== 64'h52) $display("FAIL stall_data got=%0h exp=52", get_wd(1)); else n_pass++;
        n_checks++; if (dc_q.size() !== 1) $display("FAIL stall_ndone got=%0d exp=1", dc_q.size()); else n_pass++;
        n_checks++; if (get_dl(0) !== 14) $display("FAIL stall_byte_len got=%0d exp=14", get_dl(0)); else n_pass++;
        clear_logs();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 8'hFF, 64'h100 + 64'(i));
        @(negedge axi_aclk);
        TVALID = 1'b0;
        axi_aresetn = 1'b0;
        #1;
        n_checks++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0)
            $display("FAIL rstmid_wr got=%b/%0d/%0h exp=0/0/0", wr_en, wr_addr, wr_data); else n_pass++;
        n_checks++; if (done !== 1'b0 || byte_len !== '0 || trunc !== 1'b0)
            $display("FAIL rstmid_done got=%b/%0d/%b exp=0/0/0", done, byte_len, trunc); else n_pass++;
        repeat (2) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        idle(3);
        n_checks++; if (dc_q.size() !== 0) $display("FAIL rstmid_no_done got=%0d exp=0", dc_q.size()); else n_pass++;
        clear_logs();
        drive(1, 1, 1, 8'h01, 64'h77);
        idle(4);
        n_checks++; if (wa_q.size() !== 1 || get_wa(0) !== 0)
            $display("FAIL rstmid_new_pkt got=n%0d/addr%0d exp=n1/addr0", wa_q.size(), get_wa(0)); else n_pass++;
        n_checks++; if (dc_q.size() !== 1 || get_dl(0) !== 1)
            $display("FAIL rstmid_new_len got=n%0d/len%0d exp=n1/len1", dc_q.size(), get_dl(0)); else n_pass++;
        clear_logs();
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 0, 8'hFF, 64'hA0);
        drive(1, 1, 1, 8'hFF, 64'hA1);
        drive(1, 1, 0, 8'hFF, 64'hB0); mem_ready = 1'b0;
        drive(1, 1, 1, 8'hFF, 64'hB1);
        idle(5);
        mem_ready = 1'b1;
        n_checks++; if (wa_q.size() !== 2) $display("FAIL b2b_nwrites got=%0d exp=2", wa_q.size()); else n_pass++;
        n_checks++; if (get_wd(0) !== 64'hA0 || get_wd(1) !== 64'hA1)
            $display("FAIL b2b_data got=%0h,%0h exp=a0,a1", get_wd(0), get_wd(1)); else n_pass++;
        n_checks++; if (dc_q.size() !== 1) $display("FAIL b2b_ndone got=%0d exp=1", dc_q.size()); else n_pass++;
        n_checks++; if (get_dl(0) !== 16) $display("FAIL b2b_byte_len got=%0d exp=16", get_dl(0)); else n_pass++;
        clear_logs();
    endtask

    task automatic test_keep_zero();
        drive(1, 1, 0, 8'hFF, 64'h90);
        drive(1, 1, 1, 8'h00, 64'h91);
        idle(5);
        n_checks++; if (wa_q.size() !== 2 || get_wa(1) !== 1)
            $display("FAIL keep0_writes got=n%0d/addr%0d exp=n2/addr1", wa_q.size(), get_wa(1)); else n_pass++;
        n_checks++; if (dc_q.size() !== 1 || get_dl(0) !== 8)
            $display("FAIL keep0_byte_len got=n%0d/len%0d exp=n1/len8", dc_q.size(), get_dl(0)); else n_pass++;
        clear_logs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_trunc();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_keep_zero();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
